// File: rtl/multichannel_decimator_pkg.sv
// Shared types and helpers for the multichannel decimator: operating mode encoding,
// default geometry and the accumulator width rule.
package multichannel_decimator_pkg;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    localparam int DEF_DATA_WIDTH   = 12;
    localparam int DEF_NUM_CHANNELS = 2;
    localparam int DEF_MAX_LOG2     = 6;

    // A window of 2^max_log2 full-scale samples needs max_log2 extra bits of headroom.
    function automatic int acc_width(input int data_width, input int max_log2);
        return data_width + max_log2;
    endfunction

endpackage

// File: rtl/multichannel_decimator_if.sv
// Sample-in / result-out stream bundle between the ADC capture path, the decimator
// and the AXI-Stream packer.
interface multichannel_decimator_if
    import multichannel_decimator_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
);
    localparam int BUS_W = DATA_WIDTH * NUM_CHANNELS;

    logic             s_valid;
    logic [BUS_W-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [BUS_W-1:0] m_data;

    // slave: the decimator itself; master: the surrounding capture/packer logic.
    modport slave  (input  s_valid, s_data, m_ready, output m_valid, m_data);
    modport master (output s_valid, s_data, m_ready, input  m_valid, m_data);

endinterface

// File: rtl/multichannel_decimator_channel_acc.sv
// One lane of the decimator: boxcar accumulator plus the pick/average result mux.
// The result is combinational so it is ready on the edge that accepts the last sample.
module decim_channel_acc
    import multichannel_decimator_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MAX_LOG2   = DEF_MAX_LOG2,
    localparam int SHIFT_W    = $clog2(MAX_LOG2 + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         add,
    input  logic [SHIFT_W-1:0]           shift,
    input  mode_e                        mode,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0]        result
);
    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_LOG2);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;

    assign sample_ext = {{MAX_LOG2{sample[DATA_WIDTH-1]}}, sample};

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        sum    = add ? acc_q + sample_ext : sample_ext;
        // The mean lies inside the input range, so dropping the upper bits is exact.
        result = (mode == MODE_AVG) ? DATA_WIDTH'(sum >>> shift) : sample;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (load || add) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/multichannel_decimator.sv
// Integer-ratio (2^dec_log2) decimator for parallel ADC lanes: shared window counter,
// shadowed configuration, single-entry valid/ready output slot and sticky overrun.
module multichannel_decimator
    import multichannel_decimator_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter  int MAX_LOG2     = DEF_MAX_LOG2,
    localparam int LOG2_W       = $clog2(MAX_LOG2 + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          mode,
    input  logic [LOG2_W-1:0]             dec_log2,
    multichannel_decimator_if.slave       bus,
    output logic                          overrun
);
    localparam int BUS_W = DATA_WIDTH * NUM_CHANNELS;
    localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      last_idx;
    mode_e                 mode_q;
    mode_e                 eff_mode;
    logic [LOG2_W-1:0]     log2_q;
    logic [LOG2_W-1:0]     log2_clamped;
    logic [LOG2_W-1:0]     eff_log2;
    logic                  first;
    logic                  accept;
    logic                  done;
    logic [DATA_WIDTH-1:0] result_ch [NUM_CHANNELS];
    logic [BUS_W-1:0]      result;

    // The first sample of a window sees the live configuration; the rest use the shadow copy.
    always_comb begin
        log2_clamped = (dec_log2 > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : dec_log2;
        first        = (count_q == '0);
        eff_mode     = first ? mode_e'(mode) : mode_q;
        eff_log2     = first ? log2_clamped : log2_q;
        last_idx     = CNT_W'((32'd1 << eff_log2) - 32'd1);
        accept       = enable && bus.s_valid;
        done         = accept && (count_q == last_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            mode_q  <= MODE_PICK;
            log2_q  <= '0;
        end else if (!enable) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= (count_q == last_idx) ? '0 : count_q + 1'b1;
            if (first) begin
                mode_q <= eff_mode;
                log2_q <= eff_log2;
            end
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        decim_channel_acc #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_LOG2   (MAX_LOG2)
        ) u_acc (
            .clk    (clk),
            .reset  (reset),
            .clear  (!enable),
            .load   (accept && first),
            .add    (accept && !first),
            .shift  (eff_log2),
            .mode   (eff_mode),
            .sample (bus.s_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .result (result_ch[k])
        );
    end

    always_comb begin
        result = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            result[k*DATA_WIDTH +: DATA_WIDTH] = result_ch[k];
        end
    end

    // A completed result refills the slot if it is empty or draining this cycle; otherwise it is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            overrun     <= 1'b0;
        end else if (done && (!bus.m_valid || bus.m_ready)) begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= result;
        end else if (done) begin
            overrun     <= 1'b1;
        end else if (bus.m_valid && bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multichannel_decimator.sv
// Directed bench for multichannel_decimator: a table of per-cycle vectors for the
// streaming cases plus hand-written sequences for backpressure, enable and reset.
module tb_multichannel_decimator;

    localparam int DW = 12;
    localparam int NC = 2;
    localparam int ML = 6;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          mode;
    logic [LW-1:0] dec_log2;
    logic          overrun;

    multichannel_decimator_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC)) bus ();

    multichannel_decimator #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NC),
        .MAX_LOG2     (ML)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .dec_log2 (dec_log2),
        .bus      (bus),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          md;
        logic [LW-1:0] l2;
        logic          sv;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          mr;
        logic          ev;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic          eo;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic md, input logic [LW-1:0] l2, input logic sv,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic mr);
        enable      = en;
        mode        = md;
        dec_log2    = l2;
        bus.s_valid = sv;
        bus.s_data  = {d1, d0};
        bus.m_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic ev, input logic [DW-1:0] e0,
                             input logic [DW-1:0] e1, input logic eo);
        check({name, " m_valid"}, 32'(bus.m_valid), 32'(ev));
        if (ev) begin
            check({name, " ch0"}, 32'(bus.m_data[DW-1:0]), 32'(e0));
            check({name, " ch1"}, 32'(bus.m_data[2*DW-1:DW]), 32'(e1));
        end
        check({name, " overrun"}, 32'(overrun), 32'(eo));
    endtask

    function automatic void add_vec(input logic en, input logic md, input logic [LW-1:0] l2,
                                    input logic sv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                    input logic mr, input logic ev, input logic [DW-1:0] e0,
                                    input logic [DW-1:0] e1, input logic eo);
        vec_t v;
        v = '{en, md, l2, sv, d0, d1, mr, ev, e0, e1, eo};
        vecs.push_back(v);
    endfunction

    initial begin
        logic sv;
        logic [DW-1:0] a;
        logic [DW-1:0] b;

        // Pick, R=4: ch0 ramp 0..11, ch1 ramp 100..111; results at samples 3, 7, 11.
        for (int i = 0; i < 12; i++) begin
            add_vec(1'b1, 1'b0, 3'd2, 1'b1, DW'(i), DW'(100 + i), 1'b1,
                    (i % 4) == 3, DW'(i), DW'(100 + i), 1'b0);
        end
        // Average, R=4: 1..4 -> 2, -1..-4 -> -3 (floor of 2.5 and -2.5).
        for (int i = 0; i < 4; i++) begin
            add_vec(1'b1, 1'b1, 3'd2, 1'b1, DW'(i + 1), DW'(-(i + 1)), 1'b1,
                    i == 3, 12'd2, 12'hFFD, 1'b0);
        end
        // Average, R=64 at full scale; second window asks for 2^7, which clamps to 64.
        for (int i = 0; i < 64; i++) begin
            add_vec(1'b1, 1'b1, 3'd6, 1'b1, 12'h7FF, 12'h7FF, 1'b1, i == 63, 12'h7FF, 12'h7FF, 1'b0);
        end
        for (int i = 0; i < 64; i++) begin
            add_vec(1'b1, 1'b1, 3'd7, 1'b1, 12'h800, 12'h800, 1'b1, i == 63, 12'h800, 12'h800, 1'b0);
        end
        // R=1 with random s_valid gaps: each accepted sample reappears one cycle later.
        for (int i = 0; i < 24; i++) begin
            sv = 1'($urandom_range(0, 1));
            a  = DW'(i * 37 - 500);
            b  = DW'(1000 - i * 91);
            add_vec(1'b1, i >= 12, 3'd0, sv, a, b, 1'b1, sv, a, b, 1'b0);
        end

        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        check_out("reset", 1'b0, '0, '0, 1'b0);
        check("reset m_data", 32'(bus.m_data), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].md, vecs[i].l2, vecs[i].sv, vecs[i].d0, vecs[i].d1, vecs[i].mr);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].e0, vecs[i].e1, vecs[i].eo);
        end

        // Backpressure, average R=2: (10+11)/2 is held, (12+13)/2 is dropped.
        drive(1'b1, 1'b1, 3'd1, 1'b0, '0, '0, 1'b1);
        tick();
        check_out("bp drain", 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b1, 3'd1, 1'b1, 12'd10, 12'd10, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'd1, 1'b1, 12'd11, 12'd11, 1'b0);
        tick();
        check_out("bp first", 1'b1, 12'd10, 12'd10, 1'b0);
        drive(1'b1, 1'b1, 3'd1, 1'b1, 12'd12, 12'd12, 1'b0);
        tick();
        check_out("bp mid", 1'b1, 12'd10, 12'd10, 1'b0);
        drive(1'b1, 1'b1, 3'd1, 1'b1, 12'd13, 12'd13, 1'b0);
        tick();
        check_out("bp drop", 1'b1, 12'd10, 12'd10, 1'b1);
        drive(1'b1, 1'b1, 3'd1, 1'b0, '0, '0, 1'b1);
        tick();
        check_out("bp released", 1'b0, '0, '0, 1'b1);

        // enable=0 keeps a pending result, ignores samples and discards a partial window.
        drive(1'b1, 1'b0, 3'd0, 1'b1, 12'd77, 12'd78, 1'b0);
        tick();
        check_out("en pending", 1'b1, 12'd77, 12'd78, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 3'd2, 1'b1, DW'(i + 1), DW'(i + 1), 1'b0);
            tick();
        end
        check_out("en off hold", 1'b1, 12'd77, 12'd78, 1'b1);
        drive(1'b0, 1'b0, 3'd2, 1'b0, '0, '0, 1'b1);
        tick();
        check_out("en off drain", 1'b0, '0, '0, 1'b1);
        drive(1'b1, 1'b0, 3'd2, 1'b1, 12'd20, 12'd20, 1'b1);
        tick();
        drive(1'b1, 1'b0, 3'd2, 1'b1, 12'd21, 12'd21, 1'b1);
        tick();
        drive(1'b0, 1'b0, 3'd2, 1'b1, 12'd22, 12'd22, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 3'd2, 1'b1, DW'(30 + i), DW'(40 + i), 1'b1);
            tick();
            check_out($sformatf("en restart%0d", i), i == 3, DW'(30 + i), DW'(40 + i), 1'b1);
        end

        // Reset mid-window, then a fresh window whose length ignores a mid-window dec_log2 change.
        drive(1'b1, 1'b1, 3'd2, 1'b1, 12'd100, 12'd100, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_out("async reset", 1'b0, '0, '0, 1'b0);
        check("async reset m_data", 32'(bus.m_data), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, (i == 0) ? 3'd2 : 3'd1, 1'b1, 12'd5, 12'd5, 1'b1);
            tick();
            check_out($sformatf("post reset%0d", i), i == 3, 12'd5, 12'd5, 1'b0);
        end
        drive(1'b1, 1'b1, 3'd1, 1'b0, '0, '0, 1'b1);
        tick();
        check_out("post reset idle", 1'b0, '0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
